// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the instruction register / datapath and the multi-cycle control unit.
// The control unit takes the master view; the datapath takes the slave view.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             PCEn;
  logic [1:0]       PCSrc;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       RegDst;
  logic [1:0]       MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             print;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output PCEn, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, print, illegal, state, instr_retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  PCEn, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, print, illegal, state, instr_retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback and driving the shared-datapath controls.
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4; waits for mem_ready
// DECODE    | precompute branch target, dispatch on opcode
// MEM_ADDR  | effective address rs+imm for lw/sw
// MEM_RD    | data read at ALUOut; waits for mem_ready
// MEM_WB    | write MDR to rt
// MEM_WR    | data write at ALUOut; waits for mem_ready
// R_EXE     | R-type ALU op
// R_WB      | write ALUOut to rd
// I_EXE     | addi ALU op
// I_WB      | write ALUOut to rt
// BRANCH    | compare, conditional PC load (beq/bne)
// JUMP      | PC <- jump target
// JAL       | PC <- jump target, $31 <- PC
// LUI_WB    | write imm<<16 to rt
// PRINT     | print strobe for PRINT_CYCLES cycles
// TRAP      | illegal opcode, halted until reset
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter int PRINT_CYCLES    = 1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EXE, S_R_WB,
    S_I_EXE, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_LUI_WB, S_PRINT, S_TRAP
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_PRINT = 6'b111111;

  localparam int            PW         = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;
  localparam logic [PW-1:0] PRINT_LOAD = PW'(PRINT_CYCLES - 1);

  state_t           cur, nxt;
  logic [PW-1:0]    pcnt;
  logic [CNT_W-1:0] retired;
  logic             illegal_q;
  logic             rdy, op_known;
  logic             unused_funct;

  logic       pcen, iord, mrd, mwr, irw, rw, srca, prt;
  logic [1:0] pcsrc, regdst, m2r, srcb, aluop;

  assign rdy          = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign op_known     = bus.opcode inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                                           OP_J, OP_JAL, OP_LUI, OP_PRINT};
  assign unused_funct = ^bus.funct;

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_FETCH:    if (rdy) nxt = S_DECODE;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_R:          nxt = S_R_EXE;
          OP_ADDI:       nxt = S_I_EXE;
          OP_LW, OP_SW:  nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_J:          nxt = S_JUMP;
          OP_JAL:        nxt = S_JAL;
          OP_LUI:        nxt = S_LUI_WB;
          OP_PRINT:      nxt = S_PRINT;
          default:       nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEM_ADDR: nxt = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (rdy) nxt = S_MEM_WB;
      S_MEM_WR:   if (rdy) nxt = S_FETCH;
      S_R_EXE:    nxt = S_R_WB;
      S_I_EXE:    nxt = S_I_WB;
      S_PRINT:    if (pcnt == '0) nxt = S_FETCH;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_FETCH;
    endcase
  end

  // Retire counts every return to FETCH except the illegal-opcode skip out of DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= S_FETCH;
      pcnt      <= '0;
      retired   <= '0;
      illegal_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt == S_PRINT && cur != S_PRINT)
        pcnt <= PRINT_LOAD;
      else if (cur == S_PRINT && pcnt != '0)
        pcnt <= pcnt - PW'(1);
      if (nxt == S_FETCH && cur != S_FETCH && cur != S_DECODE)
        retired <= retired + CNT_W'(1);
      if (nxt == S_TRAP)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    pcen = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0; rw = 1'b0;
    srca = 1'b0; prt = 1'b0;
    pcsrc = 2'b00; regdst = 2'b00; m2r = 2'b00; srcb = 2'b00; aluop = 2'b00;
    unique case (cur)
      S_FETCH:    begin mrd = 1'b1; srcb = 2'b01; irw = rdy; pcen = rdy; end
      S_DECODE:   srcb = 2'b11;
      S_MEM_ADDR: begin srca = 1'b1; srcb = 2'b10; end
      S_MEM_RD:   begin mrd = 1'b1; iord = 1'b1; end
      S_MEM_WB:   begin m2r = 2'b01; rw = 1'b1; end
      S_MEM_WR:   begin mwr = 1'b1; iord = 1'b1; end
      S_R_EXE:    begin srca = 1'b1; aluop = 2'b10; end
      S_R_WB:     begin regdst = 2'b01; rw = 1'b1; end
      S_I_EXE:    begin srca = 1'b1; srcb = 2'b10; end
      S_I_WB:     rw = 1'b1;
      S_BRANCH: begin
        srca  = 1'b1;
        aluop = 2'b01;
        pcsrc = 2'b01;
        pcen  = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
      end
      S_JUMP:     begin pcen = 1'b1; pcsrc = 2'b10; end
      S_JAL:      begin pcen = 1'b1; pcsrc = 2'b10; regdst = 2'b10; m2r = 2'b11; rw = 1'b1; end
      S_LUI_WB:   begin m2r = 2'b10; rw = 1'b1; end
      S_PRINT:    prt = 1'b1;
      default:    ;
    endcase
  end

  // Outputs are gated by rst_n so a pending write drops as soon as reset asserts.
  assign bus.PCEn          = rst_n & pcen;
  assign bus.PCSrc         = rst_n ? pcsrc : 2'b00;
  assign bus.IorD          = rst_n & iord;
  assign bus.MemRead       = rst_n & mrd;
  assign bus.MemWrite      = rst_n & mwr;
  assign bus.IRWrite       = rst_n & irw;
  assign bus.RegDst        = rst_n ? regdst : 2'b00;
  assign bus.MemtoReg      = rst_n ? m2r : 2'b00;
  assign bus.RegWrite      = rst_n & rw;
  assign bus.ALUSrcA       = rst_n & srca;
  assign bus.ALUSrcB       = rst_n ? srcb : 2'b00;
  assign bus.ALUOp         = rst_n ? aluop : 2'b00;
  assign bus.print         = rst_n & prt;
  assign bus.illegal       = rst_n & (illegal_q |
                             (~TRAP_ON_ILLEGAL & (cur == S_DECODE) & ~op_known));
  assign bus.state         = rst_n ? cur : S_FETCH;
  assign bus.instr_retired = rst_n ? retired : '0;
endmodule
